// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-bus master port between the I-cache and D-cache,
// granting whole-line transactions round-robin and draining flushed I-side reads.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_reqack,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wvalid,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rack
);
    localparam int CW = $clog2(BEATS);
    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
    state_t state, state_n;
    logic owner_d, owner_d_n, we, we_n, discard, discard_n, last_d, last_d_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic i_ok, grant_d, last_beat, rbeat;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            cnt     <= '0;
            discard <= 1'b0;
            last_d  <= 1'b1;
        end else begin
            state   <= state_n;
            owner_d <= owner_d_n;
            we      <= we_n;
            addr    <= addr_n;
            cnt     <= cnt_n;
            discard <= discard_n;
            last_d  <= last_d_n;
        end
    end
    always_comb begin
        i_ok      = i_req & ~i_cancel;
        grant_d   = d_req & (~i_ok | ~last_d);
        last_beat = cnt == CW'(BEATS - 1);
        rbeat     = (state == RDATA) & bus_rvalid;
        state_n   = state;
        owner_d_n = owner_d;
        we_n      = we;
        addr_n    = addr;
        cnt_n     = cnt;
        last_d_n  = last_d;
        discard_n = discard | (i_cancel & ~owner_d & ((state == ADDR) | (state == RDATA)));
        case (state)
            IDLE: begin
                discard_n = 1'b0;
                if (i_ok | d_req) begin
                    state_n   = ADDR;
                    owner_d_n = grant_d;
                    last_d_n  = grant_d;
                    we_n      = grant_d & d_we;
                    addr_n    = grant_d ? d_addr : i_addr;
                end
            end
            ADDR: begin
                if (bus_reqack) begin
                    state_n = we ? WDATA : RDATA;
                    cnt_n   = '0;
                end
            end
            WDATA: begin
                cnt_n   = cnt + 1'b1;
                state_n = last_beat ? IDLE : WDATA;
            end
            default: begin
                if (bus_rvalid) begin
                    cnt_n   = cnt + 1'b1;
                    state_n = last_beat ? IDLE : RDATA;
                end
            end
        endcase
    end
    assign bus_req    = state == ADDR;
    assign bus_we     = we;
    assign bus_addr   = addr;
    assign bus_wvalid = state == WDATA;
    assign bus_wdata  = d_wdata;
    assign d_wnext    = bus_wvalid;
    assign bus_rack   = rbeat;
    // A cancel in the same cycle as a beat must already hide that beat.
    assign i_rvalid   = rbeat & ~owner_d & ~discard & ~i_cancel;
    assign i_done     = i_rvalid & last_beat;
    assign d_rvalid   = rbeat & owner_d;
    assign d_done     = (bus_wvalid | d_rvalid) & last_beat;
    assign i_rdata    = bus_rdata;
    assign d_rdata    = bus_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with scoreboard queues for read beats and write beats.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, i_cancel = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
    logic        bus_reqack = 1'b0, bus_rvalid = 1'b0;
    logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
    logic        bus_req, bus_we, bus_wvalid, bus_rack;
    logic [63:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic [63:0] qi[$], qd[$], qw[$];
    int n_assert = 0, n_fail = 0, n_idone = 0, n_ddone = 0, n_wv = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wnext(d_wnext), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_reqack(bus_reqack),
        .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rack(bus_rack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk(tag, {56'd0, bus_req, bus_wvalid, bus_rack, i_rvalid, i_done, d_rvalid, d_done, d_wnext}, 64'd0);
        step();
    endtask

    task automatic grant_check(input logic [63:0] a, input logic w, input int ack_at, input int cancel_w);
        for (int k = 0; k <= ack_at; k++) begin
            bus_reqack = (k == ack_at);
            if (k == cancel_w) begin i_cancel = 1'b1; i_req = 1'b0; end else i_cancel = 1'b0;
            @(negedge clk);
            chk("bus_req", bus_req, 1);
            chk("bus_addr", bus_addr, a);
            chk("bus_we", bus_we, w);
            step();
        end
        bus_reqack = 1'b0;
        i_cancel = 1'b0;
    endtask

    task automatic read_beats(input logic [63:0] base, input bit to_d, input int keep,
                              input int cancel_k, input int gap_k, input int reset_k);
        for (int k = 0; k < 8; k++) begin
            if (k == gap_k) begin
                bus_rvalid = 1'b0;
                @(negedge clk);
                chk("gap_rack", bus_rack, 0);
                step();
            end
            bus_rvalid = 1'b1;
            bus_rdata = base + 64'(k);
            if (k == cancel_k) begin i_cancel = 1'b1; i_req = 1'b0; end else i_cancel = 1'b0;
            if (k == reset_k) begin
                reset = 1'b1;
                step();
                reset = 1'b0; bus_rvalid = 1'b0; i_req = 1'b0; d_req = 1'b0;
                return;
            end
            if (k < keep) begin
                if (to_d) qd.push_back(base + 64'(k)); else qi.push_back(base + 64'(k));
            end
            @(negedge clk);
            chk("rack", bus_rack, 1);
            if (to_d) chk("d_done", d_done, 64'(k == 7));
            else chk("i_done", i_done, 64'(k == 7 && keep == 8));
            step();
        end
        bus_rvalid = 1'b0;
        i_cancel = 1'b0;
    endtask

    task automatic write_beats(input logic [63:0] start);
        logic [63:0] v;
        v = start;
        for (int k = 0; k < 8; k++) begin
            d_wdata = v;
            qw.push_back(v);
            @(negedge clk);
            chk("wnext", d_wnext, 1);
            chk("w_done", d_done, 64'(k == 7));
            if (d_wnext) v = v + 1;
            step();
        end
    endtask

    // Scoreboard side: every delivered beat must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_rvalid) begin
                if (qi.size() == 0) chk("i_unexpected", i_rvalid, 0);
                else chk("i_rdata", i_rdata, qi.pop_front());
            end
            if (d_rvalid) begin
                if (qd.size() == 0) chk("d_unexpected", d_rvalid, 0);
                else chk("d_rdata", d_rdata, qd.pop_front());
            end
            if (bus_wvalid) begin
                if (qw.size() == 0) chk("w_unexpected", bus_wvalid, 0);
                else chk("bus_wdata", bus_wdata, qw.pop_front());
            end
            n_idone += int'(i_done);
            n_ddone += int'(d_done);
            n_wv += int'(bus_wvalid);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        @(negedge clk);
        chk("reset_outputs", {56'd0, bus_req, bus_wvalid, bus_rack, i_rvalid, i_done, d_rvalid, d_done, bus_we}, 64'd0);
        step();
        reset = 1'b0;
        // contention: I first, then D, then re-raised I
        i_req = 1'b1; i_addr = 64'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h2000;
        expect_idle("tie_idle");
        grant_check(64'h1000, 1'b0, 2, -1);
        read_beats(64'h10, 1'b0, 8, -1, -1, -1);
        i_addr = 64'h1040;
        expect_idle("i_done_gap");
        grant_check(64'h2000, 1'b0, 0, -1);
        read_beats(64'h20, 1'b1, 8, -1, 2, -1);
        d_req = 1'b0;
        expect_idle("d_done_gap");
        grant_check(64'h1040, 1'b0, 1, -1);
        read_beats(64'h30, 1'b0, 8, -1, -1, -1);
        i_req = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 64'hdead;
        expect_idle("stray_rvalid");
        bus_rvalid = 1'b0; i_req = 1'b1; i_cancel = 1'b1;
        expect_idle("req_cancel_same");
        i_req = 1'b0; i_cancel = 1'b0;
        expect_idle("req_cancel_no_grant");
        chk("contention_i_done", 64'(n_idone), 2);
        chk("contention_d_done", 64'(n_ddone), 1);
        // D write-back
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h3000;
        expect_idle("wr_idle");
        grant_check(64'h3000, 1'b1, 0, -1);
        write_beats(64'h100);
        d_req = 1'b0; d_we = 1'b0;
        expect_idle("wr_after");
        chk("wvalid_count", 64'(n_wv), 8);
        chk("wr_d_done", 64'(n_ddone), 2);
        // cancel during address phase, D pending behind it
        i_req = 1'b1; i_addr = 64'h4000; d_req = 1'b1; d_addr = 64'h5000;
        expect_idle("cadr_idle");
        grant_check(64'h4000, 1'b0, 3, 1);
        read_beats(64'h40, 1'b0, 0, -1, -1, -1);
        expect_idle("cadr_after");
        grant_check(64'h5000, 1'b0, 0, -1);
        read_beats(64'h50, 1'b1, 8, -1, -1, -1);
        d_req = 1'b0;
        expect_idle("cadr_d_after");
        // cancel at read beat 3
        i_req = 1'b1; i_addr = 64'h6000;
        expect_idle("crd_idle");
        grant_check(64'h6000, 1'b0, 0, -1);
        read_beats(64'h60, 1'b0, 3, 3, -1, -1);
        expect_idle("crd_after");
        chk("cancel_no_i_done", 64'(n_idone), 2);
        // reset mid-read at beat 4, then I wins the fresh tie
        i_req = 1'b1; i_addr = 64'h7000;
        expect_idle("rst_idle");
        grant_check(64'h7000, 1'b0, 0, -1);
        read_beats(64'h70, 1'b0, 8, -1, -1, 4);
        @(negedge clk);
        chk("post_reset", {56'd0, bus_req, bus_wvalid, bus_rack, i_rvalid, i_done, d_rvalid, d_done, bus_we}, 64'd0);
        step();
        i_req = 1'b1; i_addr = 64'h8000; d_req = 1'b1; d_addr = 64'h9000;
        expect_idle("rst_tie_idle");
        grant_check(64'h8000, 1'b0, 0, -1);
        read_beats(64'h80, 1'b0, 8, -1, -1, -1);
        i_req = 1'b0;
        expect_idle("rst_i_after");
        grant_check(64'h9000, 1'b0, 0, -1);
        read_beats(64'h90, 1'b1, 8, -1, -1, -1);
        d_req = 1'b0;
        expect_idle("final_idle");
        chk("qi_empty", 64'(qi.size()), 0);
        chk("qd_empty", 64'(qd.size()), 0);
        chk("qw_empty", 64'(qw.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory-bus master port between the instruction-fetch cache (I-side) and the data cache (D-side). Each granted request is a whole-line transaction of BEATS data beats; the arbiter holds its grant until the transaction ends. It sequences the address phase and the data phase, and alternates grants round-robin when both sides contend. An I-side request orphaned by a pipeline flush is drained silently, so the bus protocol stays intact.

## Interface
- ADDR_W, 64, byte address width
- DATA_W, 64, bus beat width
- BEATS, 8, beats per line (power of two, >=2)

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  I-side line read request; held until i_done or i_cancel
- i_addr  in  ADDR_W  I-side line address, stable while i_req
- i_cancel  in  1  I-side flush: abandon current/pending I request
- i_rvalid  out  1  I-side read beat valid
- i_rdata  out  DATA_W  I-side read beat data
- i_done  out  1  one-cycle pulse: I line complete
- d_req  in  1  D-side request; held until d_done
- d_we  in  1  D-side write-back (1) / line read (0), stable while d_req
- d_addr  in  ADDR_W  D-side line address
- d_wdata  in  DATA_W  current write beat
- d_wnext  out  1  write beat consumed; D side presents the next beat next cycle
- d_rvalid  out  1  D-side read beat valid
- d_rdata  out  DATA_W  D-side read beat data
- d_done  out  1  one-cycle pulse: D transaction complete
- bus_req  out  1  address-phase request
- bus_we  out  1  write transaction
- bus_addr  out  ADDR_W  transaction address
- bus_reqack  in  1  address phase accepted
- bus_wdata  out  DATA_W  write beat
- bus_wvalid  out  1  write beat valid (bus always accepts)
- bus_rvalid  in  1  read beat valid
- bus_rdata  in  DATA_W  read beat data
- bus_rack  out  1  read beat acknowledged

## Operation
- States: IDLE, ADDR, WDATA, RDATA.
- IDLE: if a request is pending, latch owner, address and we; go to ADDR. Contention: grant the side not granted last. last_grant resets to D, so I wins the first tie. i_req with i_cancel high in the same cycle is not granted.
- ADDR: bus_req=1 with registered bus_addr/bus_we, held constant until bus_reqack. On ack: WDATA if we, otherwise RDATA. Beat counter cleared.
- WDATA: bus_wvalid=1, bus_wdata=d_wdata and d_wnext=1 every cycle for BEATS cycles. Counter increments each beat. On the last beat, d_done=1 and go to IDLE.
- RDATA: bus_rack=bus_rvalid. Each bus_rvalid beat is forwarded combinationally to the owner's rvalid/rdata, and the counter increments. On the last beat, the owner's done=1 and go to IDLE.
- Cancel:
  - i_cancel while I owns ADDR or RDATA sets a sticky discard flag.
  - The transaction still completes on the bus: bus_req is held until ack and all beats are acked.
  - While discard is set, i_rvalid and i_done are suppressed, including a beat in the same cycle as i_cancel.
  - Discard clears on return to IDLE.
  - i_cancel in IDLE, or while D owns the bus, has no effect.
- Counter width is log2(BEATS); it wraps to 0 after the last beat.
- Idle outputs: all bus_* valids/reqs are 0; bus_addr/bus_wdata are don't-care but registered-stable; d_rdata/i_rdata mirror bus_rdata.
- bus_rvalid outside RDATA is protocol error: ignored, bus_rack=0.

## Timing
- Reset: state IDLE, counter 0, discard 0, last_grant D. All valid/req/done/ack outputs are 0 in the cycle after reset is sampled.
- Reset mid-transaction aborts immediately without draining; the bus is reset by the same signal.
- Grant latency: a request seen in IDLE at cycle N gives bus_req=1 at N+1.
- Done to next grant: done pulse at cycle M; IDLE at M+1; next bus_req earliest at M+2.
- Write line: BEATS consecutive cycles after the cycle following bus_reqack.
- Read beats: zero-cycle forward; gaps in bus_rvalid are allowed.

## Test plan
- I read alone, BEATS=8: i_req at cycle 0, bus_reqack at cycle 3, beats 0x10..0x17 on consecutive cycles -> bus_req high cycles 1-3; 8 i_rvalid beats with matching data; i_done with beat 0x17; no D outputs.
- Contention: i_req and d_req both rise at cycle 0 after reset -> I granted first; D's bus_req starts 2 cycles after i_done. Re-raise both -> D granted (round-robin).
- D write-back: d_we=1, d_wdata incremented on each d_wnext -> exactly 8 bus_wvalid/d_wnext cycles; bus_wdata sequence matches; d_done on the 8th beat.
- Cancel in ADDR: i_cancel pulsed before bus_reqack -> bus_req stays high until ack; all 8 beats acked; i_rvalid and i_done never assert; pending d_req is granted afterwards.
- Cancel during RDATA at beat 3 (same cycle) -> beats 0-2 delivered; beat 3 onward suppressed; no i_done; return to IDLE after beat 7.
- Reset asserted mid-RDATA at beat 4 -> next cycle: IDLE, all outputs 0; fresh i_req is granted with the I-first tie rule.
